// File: rtl/dbus_access_ctrl_pkg.sv
// Shared types and encode helpers for the memory-stage data-bus sequencer.
// Holds the memory op, bus size and FSM state enums plus alignment/strobe/size rules.
package dbus_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  function automatic logic is_misaligned(input mem_t t, input logic [1:0] lsb);
    logic m;
    case (t)
      MEM_LH, MEM_LHU, MEM_SH: m = lsb[0];
      MEM_LW, MEM_SW:          m = (lsb != 2'b00);
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic msize_t size_of(input mem_t t);
    msize_t s;
    case (t)
      MEM_LB, MEM_LBU, MEM_SB: s = MSIZE1;
      MEM_LH, MEM_LHU, MEM_SH: s = MSIZE2;
      default:                 s = MSIZE4;
    endcase
    return s;
  endfunction

  // Loads never write, so only store types produce enables
  function automatic logic [3:0] strobe_of(input mem_t t, input logic [1:0] lsb);
    logic [3:0] s;
    case (t)
      MEM_SB:  s = 4'b0001 << lsb;
      MEM_SH:  s = 4'b0011 << {lsb[1], 1'b0};
      MEM_SW:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dbus_access_ctrl_readdata.sv
// Load extractor: picks the addressed byte/half out of the raw bus word and
// sign- or zero-extends it; the mirror of the store write-data aligner.
module dbus_access_ctrl_readdata
  import dbus_access_ctrl_pkg::*;
(
  input  logic [1:0]  byte_sel,
  input  mem_t        mem_type,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to the load type
  always_comb begin
    byte_s = raw[{byte_sel, 3'b000} +: 8];
    half_s = raw[{byte_sel[1], 4'b0000} +: 16];
    case (mem_type)
      MEM_LB:  ext = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: ext = {24'h000000, byte_s};
      MEM_LH:  ext = {{16{half_s[15]}}, half_s};
      MEM_LHU: ext = {16'h0000, half_s};
      MEM_LW:  ext = raw;
      default: ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dbus_access_ctrl.sv
// Memory-stage data-bus sequencer: issues the request, waits for the bus
// handshake, stalls the pipe meanwhile and registers the extended load result.
module dbus_access_ctrl
  import dbus_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  mem_t              mem_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output msize_t            dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              stall_o,
  output logic [DATA_W-1:0] rd,
  output logic              misalign
);

  dbus_state_t       state_r;
  logic              killed_r;
  mem_t              type_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wd_r;
  logic [DATA_W-1:0] rd_r;

  logic              misalign_s;
  logic              want_s;
  logic              issue_s;
  logic              req_phase_s;
  logic              stall_s;
  mem_t              cur_type_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [DATA_W-1:0] cur_wd_s;
  logic [DATA_W-1:0] ext_s;

  // Op decode; resetn gates issue so no request escapes while reset is held
  always_comb begin
    misalign_s  = is_misaligned(mem_type, addr[1:0]);
    want_s      = resetn & op_valid & (mem_type != MEM_NONE) & ~misalign_s & ~flush;
    issue_s     = want_s & (state_r == IDLE);
    req_phase_s = issue_s | (state_r == REQ);
  end

  // Request fields come straight from the stage in IDLE, from the captured copy afterwards
  always_comb begin
    if (state_r == IDLE) begin
      cur_type_s = mem_type;
      cur_addr_s = addr;
      cur_wd_s   = wd;
    end else begin
      cur_type_s = type_r;
      cur_addr_s = addr_r;
      cur_wd_s   = wd_r;
    end
  end

  // Pipeline hold; a killed transaction only stalls a new op that wants the bus
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = want_s;
      REQ:     stall_s = 1'b1;
      WAIT:    stall_s = killed_r ? want_s : 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  dbus_access_ctrl_readdata u_readdata (
    .byte_sel (cur_addr_s[1:0]),
    .mem_type (cur_type_s),
    .raw      (dresp_data),
    .ext      (ext_s)
  );

  // Bus handshake FSM with op capture, kill tracking and registered load result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= IDLE;
      killed_r <= 1'b0;
      type_r   <= MEM_NONE;
      addr_r   <= '0;
      wd_r     <= '0;
      rd_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            type_r <= mem_type;
            addr_r <= addr;
            wd_r   <= wd;
            if (dresp_addr_ok && dresp_data_ok) begin
              state_r <= DONE;
              rd_r    <= ext_s;
            end else if (dresp_addr_ok) begin
              state_r <= WAIT;
            end else begin
              state_r <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              if (flush) begin
                state_r <= IDLE;
              end else begin
                state_r <= DONE;
                rd_r    <= ext_s;
              end
            end else begin
              state_r  <= WAIT;
              killed_r <= flush;
            end
          end else if (flush) begin
            state_r <= IDLE;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          // An accepted transaction cannot be cancelled: a flush only discards its data
          if (dresp_data_ok) begin
            killed_r <= 1'b0;
            if (killed_r || flush) begin
              state_r <= IDLE;
            end else begin
              state_r <= DONE;
              rd_r    <= ext_s;
            end
          end else begin
            killed_r <= killed_r | flush;
            state_r  <= WAIT;
          end
        end
        DONE: begin
          if (flush || !pipe_stall) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          killed_r <= 1'b0;
        end
      endcase
    end
  end

  assign dreq_valid  = req_phase_s;
  assign dreq_addr   = cur_addr_s;
  assign dreq_size   = size_of(cur_type_s);
  assign dreq_strobe = strobe_of(cur_type_s, cur_addr_s[1:0]);
  assign dreq_data   = cur_wd_s;
  assign stall_o     = stall_s;
  assign rd          = rd_r;
  assign misalign    = misalign_s;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Bench for dbus_access_ctrl: directed table, random ops against a transaction
// model, and hand-written flush / stall / reset sequences.
module tb_dbus_access_ctrl;
  import dbus_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  mem_t        mem_type = MEM_NONE;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;
  logic        pipe_stall = 1'b0;
  logic        flush = 1'b0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  msize_t      dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = 32'h0;
  logic        stall_o;
  logic [31:0] rd;
  logic        misalign;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = 32'h0;

  dbus_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .mem_type(mem_type),
    .addr(addr), .wd(wd), .pipe_stall(pipe_stall), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .stall_o(stall_o), .rd(rd), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_t        t;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] raw;
    int          ad;
    int          dd;
    logic        mis;
    logic [3:0]  strobe;
    msize_t      size;
    logic [31:0] rdv;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [3:0]  strobe;
    logic [31:0] size;
    int          req;
    int          stall_bad;
    int          field_bad;
    logic        done_stall;
    logic [31:0] rdv;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes, derived from the op type
  function automatic int nbytes(input mem_t t);
    case (t)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit m_store(input mem_t t);
    return (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
  endfunction

  function automatic bit m_misalign(input mem_t t, input logic [31:0] a);
    int n;
    n = nbytes(t);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [3:0] m_strobe(input mem_t t, input logic [31:0] a);
    int n;
    n = nbytes(t);
    if (!m_store(t)) return 4'h0;
    return 4'((((1 << n) - 1) << (a % 4)));
  endfunction

  function automatic msize_t m_size(input mem_t t);
    int n;
    n = nbytes(t);
    if (n == 1) return MSIZE1;
    if (n == 2) return MSIZE2;
    return MSIZE4;
  endfunction

  function automatic logic [31:0] m_rd(input mem_t t, input logic [31:0] a, input logic [31:0] raw);
    int          n;
    logic [31:0] v;
    bit          sgn;
    n   = nbytes(t);
    sgn = (t == MEM_LB) || (t == MEM_LH);
    if (m_store(t) || n == 0) return 32'h0;
    if (n == 4) return raw;
    v = raw >> (8 * (a % 4));
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = v & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  // Drive one op with a bus responder giving addr_ok after ad cycles and data_ok dd later
  task automatic run_op(input mem_t t, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] raw, input int ad, input int dd, output obs_t o);
    o = '{default: 0};
    op_valid = 1'b1; mem_type = t; addr = a; wd = w; flush = 1'b0; pipe_stall = 1'b0;
    if (t == MEM_NONE || m_misalign(t, a)) begin
      for (int k = 0; k < 2; k++) begin
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        if (k == 0) o.mis = misalign;
        if (dreq_valid) o.req++;
        if (stall_o !== 1'b0) o.stall_bad++;
        o.rdv = rd;
        @(posedge clk); #1;
      end
    end else begin
      for (int k = 0; k <= ad + dd; k++) begin
        dresp_addr_ok = (k == ad);
        dresp_data_ok = (k == ad + dd);
        dresp_data    = (k == ad + dd) ? raw : $urandom;
        @(negedge clk);
        if (k == 0) begin
          o.mis = misalign; o.strobe = dreq_strobe; o.size = 32'(dreq_size);
        end
        if (dreq_valid) begin
          o.req++;
          if (dreq_addr !== a || dreq_data !== w || dreq_strobe !== o.strobe || 32'(dreq_size) !== o.size)
            o.field_bad++;
        end
        if (stall_o !== 1'b1) o.stall_bad++;
        @(posedge clk); #1;
      end
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
      @(negedge clk);
      o.done_stall = stall_o;
      o.rdv = rd;
      if (dreq_valid) o.req++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0; mem_type = MEM_NONE;
  endtask

  task automatic apply_and_check(input string tag, input mem_t t, input logic [31:0] a,
                                 input logic [31:0] w, input logic [31:0] raw, input int ad,
                                 input int dd, input logic exp_mis, input logic [3:0] exp_strobe,
                                 input msize_t exp_size, input logic [31:0] exp_rd);
    obs_t o;
    run_op(t, a, w, raw, ad, dd, o);
    check($sformatf("%s.misalign", tag), o.mis, exp_mis);
    if (!exp_mis && t != MEM_NONE) begin
      check($sformatf("%s.strobe", tag), o.strobe, exp_strobe);
      check($sformatf("%s.size", tag), o.size, exp_size);
      check($sformatf("%s.req_cycles", tag), o.req, ad + 1);
      check($sformatf("%s.stall_busy", tag), o.stall_bad, 0);
      check($sformatf("%s.fields", tag), o.field_bad, 0);
      check($sformatf("%s.done_stall", tag), o.done_stall, 0);
      check($sformatf("%s.rd", tag), o.rdv, exp_rd);
      last_rd = exp_rd;
    end else begin
      check($sformatf("%s.no_req", tag), o.req, 0);
      check($sformatf("%s.no_stall", tag), o.stall_bad, 0);
      check($sformatf("%s.rd_kept", tag), o.rdv, last_rd);
    end
  endtask

  vec_t        tbl[12];
  mem_t        rt;
  logic [3:0]  tv;
  logic [31:0] ra, rw, rr;

  initial begin
    tbl[0]  = '{MEM_SW,  32'h1000, 32'hDEADBEEF, 32'h12345678, 0, 0, 1'b0, 4'b1111, MSIZE4, 32'h0};
    tbl[1]  = '{MEM_LB,  32'h1003, 32'h0,        32'h80FF0000, 3, 2, 1'b0, 4'b0000, MSIZE1, 32'hFFFFFF80};
    tbl[2]  = '{MEM_LBU, 32'h1003, 32'h0,        32'h80FF0000, 3, 2, 1'b0, 4'b0000, MSIZE1, 32'h00000080};
    tbl[3]  = '{MEM_LH,  32'h2002, 32'h0,        32'h80011234, 1, 1, 1'b0, 4'b0000, MSIZE2, 32'hFFFF8001};
    tbl[4]  = '{MEM_LHU, 32'h2002, 32'h0,        32'h80011234, 0, 2, 1'b0, 4'b0000, MSIZE2, 32'h00008001};
    tbl[5]  = '{MEM_SH,  32'h2002, 32'hCAFE0000, 32'h0,        2, 0, 1'b0, 4'b1100, MSIZE2, 32'h0};
    tbl[6]  = '{MEM_LW,  32'h3001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, MSIZE4, 32'h0};
    tbl[7]  = '{MEM_SB,  32'h4001, 32'h00005A00, 32'h0,        0, 3, 1'b0, 4'b0010, MSIZE1, 32'h0};
    tbl[8]  = '{MEM_LW,  32'h5000, 32'h0,        32'h12345678, 2, 0, 1'b0, 4'b0000, MSIZE4, 32'h12345678};
    tbl[9]  = '{MEM_SH,  32'h6001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, MSIZE2, 32'h0};
    tbl[10] = '{MEM_LH,  32'h7000, 32'h0,        32'h00007FFF, 0, 0, 1'b0, 4'b0000, MSIZE2, 32'h00007FFF};
    tbl[11] = '{MEM_LB,  32'h7002, 32'h0,        32'h00800000, 1, 0, 1'b0, 4'b0000, MSIZE1, 32'hFFFFFF80};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.dreq_valid", dreq_valid, 1'b0);
    check("reset.stall_o", stall_o, 1'b0);
    check("reset.rd", rd, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      apply_and_check($sformatf("tbl%0d", i), tbl[i].t, tbl[i].a, tbl[i].w, tbl[i].raw,
                      tbl[i].ad, tbl[i].dd, tbl[i].mis, tbl[i].strobe, tbl[i].size, tbl[i].rdv);

    for (int i = 0; i < 40; i++) begin
      tv = 4'($urandom_range(0, 8));
      rt = mem_t'(tv);
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
      rw = $urandom;
      rr = $urandom;
      apply_and_check($sformatf("rnd%0d", i), rt, ra, rw, rr, $urandom_range(0, 3),
                      $urandom_range(0, 3), m_misalign(rt, ra), m_strobe(rt, ra), m_size(rt),
                      m_rd(rt, ra, rr));
    end

    // Flush in WAIT: transaction drains, data is discarded, next op waits for data_ok
    op_valid = 1'b1; mem_type = MEM_LW; addr = 32'h7000; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    @(negedge clk); check("wflush.req", dreq_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1; op_valid = 1'b0; mem_type = MEM_NONE; dresp_addr_ok = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("wflush.killed_stall", stall_o, 1'b0);
    check("wflush.killed_noreq", dreq_valid, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_type = MEM_LW; addr = 32'h8000; dresp_data_ok = 1'b1; dresp_data = 32'hAAAA5555;
    @(negedge clk);
    check("wflush.busy_stall", stall_o, 1'b1);
    check("wflush.busy_noreq", dreq_valid, 1'b0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0; dresp_data = 32'h0BADF00D;
    @(negedge clk);
    check("wflush.rd_unchanged", rd, last_rd);
    check("wflush.new_issue", dreq_valid, 1'b1);
    check("wflush.new_addr", dreq_addr, 32'h8000);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk);
    check("wflush.new_rd", rd, 32'h0BADF00D);
    check("wflush.done_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b0; mem_type = MEM_NONE; last_rd = 32'h0BADF00D;

    // Flush in REQ before addr_ok: request is withdrawn
    op_valid = 1'b1; mem_type = MEM_LB; addr = 32'h9000;
    @(negedge clk); check("rflush.req", dreq_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1; op_valid = 1'b0; mem_type = MEM_NONE;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("rflush.withdrawn", dreq_valid, 1'b0);
    check("rflush.stall", stall_o, 1'b0);
    check("rflush.rd", rd, last_rd);
    @(posedge clk); #1;

    // pipe_stall held in DONE: result and state hold, no reissue on exit
    op_valid = 1'b1; mem_type = MEM_LHU; addr = 32'h2002; pipe_stall = 1'b1;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h80011234;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dresp_data_ok = (k == 1); dresp_data = $urandom;
      @(negedge clk);
      check($sformatf("pstall%0d.stall", k), stall_o, 1'b0);
      check($sformatf("pstall%0d.noreq", k), dreq_valid, 1'b0);
      check($sformatf("pstall%0d.rd", k), rd, 32'h00008001);
      @(posedge clk); #1;
    end
    pipe_stall = 1'b0; dresp_data_ok = 1'b0;
    @(negedge clk); check("pstall.exit_noreq", dreq_valid, 1'b0);
    @(posedge clk); #1;
    op_valid = 1'b0; mem_type = MEM_NONE; last_rd = 32'h00008001;

    // Asynchronous reset while waiting for data
    op_valid = 1'b1; mem_type = MEM_LW; addr = 32'hA000; dresp_addr_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    #2;
    check("areset.wait_stall", stall_o, 1'b1);
    resetn = 1'b0;
    #1;
    check("areset.dreq_valid", dreq_valid, 1'b0);
    check("areset.stall_o", stall_o, 1'b0);
    check("areset.rd", rd, 32'h0);
    @(posedge clk); #1;
    op_valid = 1'b0; mem_type = MEM_NONE; resetn = 1'b1; last_rd = 32'h0;

    // Stray data_ok in IDLE is ignored
    dresp_data_ok = 1'b1; dresp_data = 32'hFFFF_FFFF;
    @(negedge clk); check("stray.stall", stall_o, 1'b0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk); check("stray.rd", rd, 32'h0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
